// File: rtl/avmm_lvds_bridge_avm_if.sv
// Master-side endpoint of the AVMM-over-LVDS bridge: pops request packets from a
// show-ahead FIFO, runs them as Avalon-MM transactions and returns responses.
module avmm_lvds_bridge_avm_if #(
  parameter int ADDR_W     = 32,
  parameter int BURSTCNT_W = 8,
  parameter int MAX_BURST  = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  req_rdreq_o,
  input  logic [31:0]           req_q_i,
  input  logic                  req_rdempty_i,
  input  logic [BURSTCNT_W-1:0] req_rdusedw_i,
  output logic [31:0]           resp_data_o,
  output logic                  resp_valid_o,
  output logic [ADDR_W-1:0]     m_address_o,
  output logic [3:0]            m_byteenable_o,
  output logic [BURSTCNT_W-1:0] m_burstcount_o,
  output logic                  m_write_o,
  output logic                  m_read_o,
  output logic [31:0]           m_writedata_o,
  input  logic [31:0]           m_readdata_i,
  input  logic                  m_waitrequest_i,
  input  logic                  m_readdatavalid_i
);

  // Beat/word counter only needs to span the largest legal burst.
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT_WD,
    S_WR,
    S_ACK,
    S_RD_CMD,
    S_RD_DATA,
    S_ERR
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic                    op_wr_q;
  logic [3:0]              be_q;
  logic [BURSTCNT_W-1:0]   bc_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    hdr_pop;
  logic                    addr_pop;
  logic                    beat_ok;
  logic                    word_ok;
  logic                    last_cnt;
  logic [15:0]             bc_lo;
  logic                    rd_vld_p0;
  logic [31:0]             rd_data_p0;

  assign last_cnt = (cnt_q == CNT_W'(1));
  assign bc_lo    = 16'(bc_q);

  always_comb begin
    state_d       = state_q;
    req_rdreq_o   = 1'b0;
    m_write_o     = 1'b0;
    m_read_o      = 1'b0;
    m_writedata_o = '0;
    hdr_pop       = 1'b0;
    addr_pop      = 1'b0;
    beat_ok       = 1'b0;
    word_ok       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!req_rdempty_i) begin
          req_rdreq_o = 1'b1;
          hdr_pop     = 1'b1;
          state_d     = S_ADDR;
        end
      end
      S_ADDR: begin
        if (!req_rdempty_i) begin
          req_rdreq_o = 1'b1;
          addr_pop    = 1'b1;
          if (bc_q == '0)   state_d = S_ERR;
          else if (op_wr_q) state_d = S_WAIT_WD;
          else              state_d = S_RD_CMD;
        end
      end
      S_WAIT_WD: begin
        // The whole burst must be queued so the FIFO cannot underrun mid-burst.
        if (req_rdusedw_i >= bc_q) state_d = S_WR;
      end
      S_WR: begin
        m_write_o     = 1'b1;
        m_writedata_o = req_q_i;
        beat_ok       = !m_waitrequest_i;
        req_rdreq_o   = !m_waitrequest_i && !req_rdempty_i;
        if (beat_ok && last_cnt) state_d = S_ACK;
      end
      S_ACK: state_d = S_IDLE;
      S_ERR: state_d = S_IDLE;
      S_RD_CMD: begin
        m_read_o = 1'b1;
        word_ok  = m_readdatavalid_i;
        if (word_ok && last_cnt)   state_d = S_IDLE;
        else if (!m_waitrequest_i) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        word_ok = m_readdatavalid_i;
        if (word_ok && last_cnt) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      op_wr_q   <= 1'b0;
      be_q      <= '0;
      bc_q      <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      rd_vld_p0 <= 1'b0;
    end else begin
      if (hdr_pop) begin
        op_wr_q <= req_q_i[31];
        be_q    <= req_q_i[30:27];
        bc_q    <= req_q_i[BURSTCNT_W-1:0];
      end
      if (addr_pop) begin
        addr_q <= req_q_i[ADDR_W-1:0];
        cnt_q  <= CNT_W'(bc_q);
      end else if (beat_ok || word_ok) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      rd_vld_p0 <= word_ok;
    end
  end

  // ---- p0: read data registered one cycle after readdatavalid ----
  always_ff @(posedge clk_i) begin
    if (word_ok) rd_data_p0 <= m_readdata_i;
  end

  assign m_address_o    = addr_q;
  assign m_byteenable_o = be_q;
  assign m_burstcount_o = bc_q;

  always_comb begin
    resp_valid_o = 1'b0;
    resp_data_o  = '0;
    if (rd_vld_p0) begin
      resp_valid_o = 1'b1;
      resp_data_o  = rd_data_p0;
    end else if (state_q == S_ACK) begin
      resp_valid_o = 1'b1;
      resp_data_o  = {16'hA5A5, bc_lo};
    end else if (state_q == S_ERR) begin
      resp_valid_o = 1'b1;
      resp_data_o  = 32'hDEAD_0000;
    end
  end

endmodule

// File: tb/tb_avmm_lvds_bridge_avm_if.sv
// Bench for avmm_lvds_bridge_avm_if: show-ahead FIFO model, Avalon slave memory
// and a packet-level reference model of expected commands and responses.
module tb_avmm_lvds_bridge_avm_if;
  localparam int ADDR_W     = 32;
  localparam int BURSTCNT_W = 8;
  localparam int MAX_BURST  = 128;
  localparam int MEM_N      = 4096;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  req_rdreq_o;
  logic [31:0]           req_q_i;
  logic                  req_rdempty_i;
  logic [BURSTCNT_W-1:0] req_rdusedw_i;
  logic [31:0]           resp_data_o;
  logic                  resp_valid_o;
  logic [ADDR_W-1:0]     m_address_o;
  logic [3:0]            m_byteenable_o;
  logic [BURSTCNT_W-1:0] m_burstcount_o;
  logic                  m_write_o;
  logic                  m_read_o;
  logic [31:0]           m_writedata_o;
  logic [31:0]           m_readdata_i;
  logic                  m_waitrequest_i;
  logic                  m_readdatavalid_i;

  always #5 clk = ~clk;

  avmm_lvds_bridge_avm_if #(
    .ADDR_W(ADDR_W), .BURSTCNT_W(BURSTCNT_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk_i(clk), .rst_i(rst_n),
    .req_rdreq_o(req_rdreq_o), .req_q_i(req_q_i), .req_rdempty_i(req_rdempty_i),
    .req_rdusedw_i(req_rdusedw_i),
    .resp_data_o(resp_data_o), .resp_valid_o(resp_valid_o),
    .m_address_o(m_address_o), .m_byteenable_o(m_byteenable_o),
    .m_burstcount_o(m_burstcount_o), .m_write_o(m_write_o), .m_read_o(m_read_o),
    .m_writedata_o(m_writedata_o), .m_readdata_i(m_readdata_i),
    .m_waitrequest_i(m_waitrequest_i), .m_readdatavalid_i(m_readdatavalid_i)
  );

  typedef struct { logic [31:0] data; bit is_rd; } resp_t;
  typedef struct { logic [31:0] addr; logic [7:0] bc; logic [3:0] be; logic [31:0] data; int idx; } wbeat_t;
  typedef struct { logic [31:0] addr; logic [7:0] bc; logic [3:0] be; } rcmd_t;

  logic [31:0] fifo_q[$];
  logic [31:0] held_q[$];
  logic [31:0] rd_pend[$];
  resp_t       exp_resp[$];
  wbeat_t      exp_wr[$];
  rcmd_t       exp_rd[$];
  int          rdv_cyc[$];
  logic [31:0] smem[MEM_N];
  logic [31:0] mem_ref[MEM_N];

  int n_tests = 0, n_fail = 0, cyc = 0;
  int rx_cnt = 0, wr_cyc_cnt = 0, wr_acc_cnt = 0, rd_cyc_cnt = 0;
  int stall_pct = 0, rdv_pct = 60;
  bit do_pop = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int midx(input logic [31:0] a);
    return int'(a % 32'(MEM_N));
  endfunction

  // Slave + FIFO model: decide transfers at negedge, update inputs 1 time unit after posedge.
  initial begin : drv
    resp_t  e;
    wbeat_t w;
    rcmd_t  r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (resp_valid_o) begin
          rx_cnt++;
          if (exp_resp.size() == 0) check("resp_unexpected", 1, 0);
          else begin
            e = exp_resp.pop_front();
            check("resp_data", resp_data_o, e.data);
            if (e.is_rd) begin
              if (rdv_cyc.size() == 0) check("rd_lat_missing", 1, 0);
              else check("rd_latency", cyc, rdv_cyc.pop_front() + 1);
            end
          end
        end
        if (m_read_o) rd_cyc_cnt++;
        if (m_write_o) begin
          wr_cyc_cnt++;
          check("rd_wr_excl", m_read_o, 0);
          check("wr_fifo_level", req_rdempty_i, 0);
          if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
          else begin
            w = exp_wr[0];
            check("wr_addr", m_address_o, w.addr);
            check("wr_bc", m_burstcount_o, w.bc);
            check("wr_be", m_byteenable_o, w.be);
            check("wr_data", m_writedata_o, w.data);
            if (!m_waitrequest_i) begin
              smem[midx(w.addr + 32'(w.idx))] = m_writedata_o;
              wr_acc_cnt++;
              void'(exp_wr.pop_front());
            end
          end
        end
        if (req_rdreq_o) begin
          check("rdreq_when_empty", fifo_q.size() == 0, 0);
          do_pop = (fifo_q.size() > 0);
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (do_pop) void'(fifo_q.pop_front());
      do_pop = 1'b0;
      if (!rst_n) begin
        rd_pend.delete();
        m_waitrequest_i   = 1'b0;
        m_readdatavalid_i = 1'b0;
      end else begin
        m_waitrequest_i = ($urandom_range(0, 99) < stall_pct);
        if (m_read_o && !m_waitrequest_i) begin
          if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
          else begin
            r = exp_rd.pop_front();
            check("rd_addr", m_address_o, r.addr);
            check("rd_bc", m_burstcount_o, r.bc);
            check("rd_be", m_byteenable_o, r.be);
          end
          for (int i = 0; i < int'(m_burstcount_o); i++)
            rd_pend.push_back(smem[midx(m_address_o + 32'(i))]);
        end
        if (rd_pend.size() > 0 && $urandom_range(0, 99) < rdv_pct) begin
          m_readdatavalid_i = 1'b1;
          m_readdata_i      = rd_pend.pop_front();
          rdv_cyc.push_back(cyc);
        end else begin
          m_readdatavalid_i = 1'b0;
          m_readdata_i      = $urandom;
        end
      end
      req_rdempty_i = (fifo_q.size() == 0);
      req_q_i       = (fifo_q.size() > 0) ? fifo_q[0] : $urandom;
      req_rdusedw_i = BURSTCNT_W'(fifo_q.size());
    end
  end

  // Reference model: expectations derived from the packet alone.
  task automatic send_pkt(input bit is_wr, input logic [3:0] be, input int bc,
                          input logic [31:0] addr, input logic [31:0] dbase,
                          input bit seq, input int first_n);
    logic [31:0] words[$];
    logic [31:0] d;
    wbeat_t w;
    rcmd_t  r;
    resp_t  e;
    words.push_back({is_wr, be, 19'($urandom), 8'(bc)});
    words.push_back(addr);
    if (bc == 0) begin
      e.data = 32'hDEAD_0000; e.is_rd = 1'b0; exp_resp.push_back(e);
    end else if (is_wr) begin
      for (int i = 0; i < bc; i++) begin
        d = seq ? dbase + 32'(i) : $urandom;
        words.push_back(d);
        w.addr = addr; w.bc = 8'(bc); w.be = be; w.data = d; w.idx = i;
        exp_wr.push_back(w);
        mem_ref[midx(addr + 32'(i))] = d;
      end
      e.data = {16'hA5A5, 16'(bc)}; e.is_rd = 1'b0; exp_resp.push_back(e);
    end else begin
      r.addr = addr; r.bc = 8'(bc); r.be = be; exp_rd.push_back(r);
      for (int i = 0; i < bc; i++) begin
        e.data = mem_ref[midx(addr + 32'(i))]; e.is_rd = 1'b1; exp_resp.push_back(e);
      end
    end
    @(posedge clk);
    for (int i = 0; i < words.size(); i++) begin
      if (i < first_n) fifo_q.push_back(words[i]);
      else held_q.push_back(words[i]);
    end
  endtask

  task automatic wait_done(input int max_cyc);
    int n = 0;
    while ((exp_resp.size() > 0 || fifo_q.size() > 0) && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    check("timeout", n >= max_cyc, 0);
    repeat (3) @(posedge clk);
    check("leftover_cmds", exp_wr.size() + exp_rd.size(), 0);
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_rdreq"}, req_rdreq_o, 0);
    check({pfx, "_resp_data"}, resp_data_o, 0);
    check({pfx, "_resp_valid"}, resp_valid_o, 0);
    check({pfx, "_address"}, m_address_o, 0);
    check({pfx, "_be"}, m_byteenable_o, 0);
    check({pfx, "_bc"}, m_burstcount_o, 0);
    check({pfx, "_write"}, m_write_o, 0);
    check({pfx, "_read"}, m_read_o, 0);
    check({pfx, "_wdata"}, m_writedata_o, 0);
  endtask

  initial begin : main
    int rx0, wc0, wa0, rc0, n, exp_cnt;
    bit is_wr;
    int bc;
    rst_n             = 1'b0;
    req_q_i           = '0;
    req_rdempty_i     = 1'b1;
    req_rdusedw_i     = '0;
    m_readdata_i      = '0;
    m_waitrequest_i   = 1'b0;
    m_readdatavalid_i = 1'b0;
    for (int i = 0; i < MEM_N; i++) begin
      smem[i]    = (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
      mem_ref[i] = (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    end
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("rst");
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Single write, no stalls: exactly one write cycle, then the ACK word.
    stall_pct = 0;
    rx0 = rx_cnt; wc0 = wr_cyc_cnt;
    send_pkt(1'b1, 4'hF, 1, 32'h100, 32'h1234_5678, 1'b1, 99);
    wait_done(200);
    check("single_wr_cycles", wr_cyc_cnt - wc0, 1);
    check("single_wr_mem", smem[32'h100], 32'h1234_5678);
    check("single_wr_resp_cnt", rx_cnt - rx0, 1);

    // Burst read of 4 with random readdatavalid gaps.
    stall_pct = 30; rdv_pct = 40;
    rx0 = rx_cnt;
    send_pkt(1'b0, 4'hF, 4, 32'h40, 32'h0, 1'b0, 99);
    wait_done(300);
    check("rd4_resp_cnt", rx_cnt - rx0, 4);

    // Burst write of 16 with only 10 data words queued at first.
    stall_pct = 0;
    wc0 = wr_cyc_cnt; wa0 = wr_acc_cnt;
    send_pkt(1'b1, 4'hC, 16, 32'h200, 32'h1000, 1'b1, 12);
    repeat (20) @(posedge clk);
    check("wait_wd_no_write", wr_cyc_cnt - wc0, 0);
    check("wait_wd_fifo_kept", fifo_q.size(), 10);
    stall_pct = 40;
    @(posedge clk);
    while (held_q.size() > 0) fifo_q.push_back(held_q.pop_front());
    wait_done(500);
    check("wr16_beats", wr_acc_cnt - wa0, 16);
    for (int i = 0; i < 16; i++) check("wr16_mem", smem[32'h200 + i], 32'h1000 + 32'(i));

    // Zero burstcount: error word, no bus access, next packet still fine.
    stall_pct = 20; rdv_pct = 60;
    wc0 = wr_cyc_cnt; rc0 = rd_cyc_cnt; rx0 = rx_cnt;
    send_pkt(1'b0, 4'hF, 0, 32'h55, 32'h0, 1'b0, 99);
    wait_done(100);
    check("err_no_write", wr_cyc_cnt - wc0, 0);
    check("err_no_read", rd_cyc_cnt - rc0, 0);
    check("err_resp_cnt", rx_cnt - rx0, 1);
    send_pkt(1'b0, 4'h3, 2, 32'h208, 32'h0, 1'b0, 99);
    wait_done(200);

    // Asynchronous reset in the middle of an 8-word read.
    stall_pct = 0; rdv_pct = 50;
    rx0 = rx_cnt; n = 0;
    send_pkt(1'b0, 4'hF, 8, 32'h300, 32'h0, 1'b0, 99);
    while (rx_cnt - rx0 < 2 && n < 500) begin @(posedge clk); n++; end
    check("rst_mid_timeout", n >= 500, 0);
    #3 rst_n = 1'b0;
    fifo_q.delete(); held_q.delete(); rd_pend.delete(); rdv_cyc.delete();
    exp_resp.delete(); exp_wr.delete(); exp_rd.delete();
    m_readdatavalid_i = 1'b0; m_waitrequest_i = 1'b0; req_rdempty_i = 1'b1; req_rdusedw_i = '0;
    #1 check_outputs_zero("rst_mid");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    rx0 = rx_cnt;
    send_pkt(1'b0, 4'hF, 1, 32'h310, 32'h0, 1'b0, 99);
    wait_done(200);
    check("post_rst_rd_cnt", rx_cnt - rx0, 1);

    // Randomized mix of 200 reads and writes.
    stall_pct = 25; rdv_pct = 60;
    rx0 = rx_cnt; exp_cnt = 0;
    for (int p = 0; p < 200; p++) begin
      n = 0;
      while (fifo_q.size() >= 48 && n < 2000) begin @(posedge clk); n++; end
      if (n >= 2000) check("rand_fifo_stuck", 1, 0);
      is_wr = $urandom_range(0, 1);
      bc    = $urandom_range(1, 16);
      exp_cnt += is_wr ? 1 : bc;
      send_pkt(is_wr, 4'($urandom), bc, 32'($urandom_range(0, MEM_N - 1)), 32'h0, 1'b0, 99);
    end
    wait_done(20000);
    check("rand_resp_count", rx_cnt - rx0, exp_cnt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
